ps2_rx: RTL and testbench

PS/2 keyboard receiver for the Spartan-3E CPU system: the input-side counterpart of the LCD output path. Samples the open-collector PS2_CLK/PS2_DATA pins, deframes 11-bit device-to-host frames, checks parity and framing, and queues good scan codes in a small FIFO. The CPU reads them through a 16-bit zero-extended read port with a pop strobe, in the same bus width as the register/ALU datapath.

---
 rtl/ps2_rx.sv | 177 +++++++++++++++++
 tb/tb_ps2_rx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver with glitch filter, frame checker and byte FIFO.
// Ports: CLK_50MHZ/reset (async low), PS2_CLK/PS2_DATA raw pins, rd_en/err_clr
//   from CPU; rd_data/rd_valid/fifo_full read side; overflow/parity_err/frame_err sticky.
module ps2_rx #(
   parameter int FILTER     = 8,
   parameter int TIMEOUT    = 50000,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic        CLK_50MHZ,
   input  logic        reset,
   input  logic        PS2_CLK,
   input  logic        PS2_DATA,
   input  logic        rd_en,
   input  logic        err_clr,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        fifo_full,
   output logic        overflow,
   output logic        parity_err,
   output logic        frame_err
);

   localparam int FW    = $clog2(FILTER + 1);
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    ck_sync_q, dt_sync_q;
   logic          filt_q, filt_dly_q;
   logic [FW-1:0] fcnt_q;
   logic          sck, sdat, fall;

   state_t        state_q;
   logic [7:0]    shift_q;
   logic [2:0]    bit_q;
   logic          par_q, push_q;
   logic [TW-1:0] to_q;
   logic          perr_q, ferr_q, ovf_q;
   logic          par_ok;

   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW-1:0] wptr_d, rptr_d;
   logic [7:0]    mem_q [DEPTH];
   logic          empty, full, pop, do_push;

   assign sck  = ck_sync_q[1];
   assign sdat = dt_sync_q[1];

   // Both synchronizers idle high, matching the open-collector bus level.
   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         ck_sync_q <= 2'b11;
         dt_sync_q <= 2'b11;
      end else begin
         ck_sync_q <= {ck_sync_q[0], PS2_CLK};
         dt_sync_q <= {dt_sync_q[0], PS2_DATA};
      end
   end

   // Any bounce shorter than FILTER cycles restarts the count.
   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         filt_q     <= 1'b1;
         filt_dly_q <= 1'b1;
         fcnt_q     <= '0;
      end else begin
         filt_dly_q <= filt_q;
         if (sck != filt_q) begin
            if (fcnt_q == FW'(FILTER - 1)) begin
               filt_q <= sck;
               fcnt_q <= '0;
            end else begin
               fcnt_q <= fcnt_q + 1'b1;
            end
         end else begin
            fcnt_q <= '0;
         end
      end
   end

   assign fall   = filt_dly_q & ~filt_q;
   assign par_ok = ^{shift_q, par_q};

   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         push_q  <= 1'b0;
         to_q    <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         // Clear first; a coincident set below overrides it.
         if (err_clr) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
         end
         if (state_q == IDLE || fall) to_q <= '0;
         else                         to_q <= to_q + 1'b1;
         unique case (state_q)
            IDLE: begin
               if (fall && !sdat) begin
                  state_q <= DATA;
                  bit_q   <= '0;
               end
            end
            DATA: begin
               if (fall) begin
                  shift_q <= {sdat, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= PARITY;
               end
            end
            PARITY: begin
               if (fall) begin
                  par_q   <= sdat;
                  state_q <= STOP;
               end
            end
            STOP: begin
               if (fall) begin
                  state_q <= IDLE;
                  if (!par_ok)    perr_q <= 1'b1;
                  else if (!sdat) ferr_q <= 1'b1;
                  else            push_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
         // A fall on the terminal cycle keeps the frame alive.
         if (state_q != IDLE && !fall && to_q == TW'(TIMEOUT - 1)) begin
            state_q <= IDLE;
            ferr_q  <= 1'b1;
            to_q    <= '0;
         end
      end
   end

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                    (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
   assign pop     = rd_en & ~empty;
   assign do_push = push_q & (~full | pop);
   assign wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
   assign rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;

   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= (ovf_q & ~err_clr) | (push_q & full & ~pop);
      end
   end

   // Storage needs no reset: rd_data is gated by the empty flag.
   always_ff @(posedge CLK_50MHZ) begin
      if (do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= shift_q;
   end

   assign rd_valid   = ~empty;
   assign fifo_full  = full;
   assign rd_data    = empty ? 16'h0000
                             : {8'h00, mem_q[rptr_q[DEPTH_LOG2-1:0]]};
   assign overflow   = ovf_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: scoreboard of expected bytes,
// one task per scenario.
module tb_ps2_rx;

   localparam int HALF = 60;
   localparam int TMO  = 50000;

   logic        clk = 1'b0;
   logic        rst_n, ps2c, ps2d, rd_en, err_clr;
   logic [15:0] rd_data;
   logic        rd_valid, fifo_full, overflow, parity_err, frame_err;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  sb [$];
   logic        exp_ovf = 1'b0;

   always #10 clk = ~clk;

   ps2_rx dut (
      .CLK_50MHZ (clk),
      .reset     (rst_n),
      .PS2_CLK   (ps2c),
      .PS2_DATA  (ps2d),
      .rd_en     (rd_en),
      .err_clr   (err_clr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .fifo_full (fifo_full),
      .overflow  (overflow),
      .parity_err(parity_err),
      .frame_err (frame_err)
   );

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [10:0] fbits(input logic [7:0] b,
                                         input logic pflip,
                                         input logic stop);
      return {stop, (~^b) ^ pflip, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int from, input int upto);
      for (int i = from; i < upto; i++) begin
         ps2d = f[i];
         cyc(HALF);
         ps2c = 1'b0;
         cyc(HALF);
         ps2c = 1'b1;
      end
   endtask

   task automatic model_push(input logic [7:0] b);
      if (sb.size() < 4) sb.push_back(b);
      else               exp_ovf = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stop);
      send_bits(fbits(b, pflip, stop), 0, 11);
      ps2d = 1'b1;
      if (!pflip && stop) model_push(b);
      cyc(HALF);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      cyc(3);
      total++;
      if ({rd_data, rd_valid, fifo_full, overflow, parity_err, frame_err} !== 21'h0) begin
         bad++;
         $display("FAIL reset_hold got=%h want=0",
                  {rd_data, rd_valid, fifo_full, overflow, parity_err, frame_err});
      end
      rst_n = 1'b1;
      cyc(5);
      total++;
      if ({rd_data, rd_valid, fifo_full, overflow, parity_err, frame_err} !== 21'h0) begin
         bad++;
         $display("FAIL reset_release got=%h want=0",
                  {rd_data, rd_valid, fifo_full, overflow, parity_err, frame_err});
      end
   endtask

   task automatic test_valid_frame();
      logic [7:0] e;
      send_bits(fbits(8'h1C, 1'b0, 1'b1), 0, 10);
      ps2d = 1'b1;
      cyc(HALF);
      ps2c = 1'b0;
      model_push(8'h1C);
      cyc(11);
      total++;
      if (rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL lat_early rd_valid got=%b want=0", rd_valid);
      end
      cyc(1);
      e = sb.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== {8'h00, e}) begin
         bad++;
         $display("FAIL lat_12 got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, {8'h00, e});
      end
      cyc(HALF - 12);
      ps2c = 1'b1;
      cyc(HALF);
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
         bad++;
         $display("FAIL pop_empty got v=%b d=%h want v=0 d=0000", rd_valid, rd_data);
      end
   endtask

   task automatic test_parity();
      send_frame(8'h1C, 1'b1, 1'b1);
      total++;
      if (rd_valid !== (sb.size() != 0) || parity_err !== 1'b1 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL parity got v=%b pe=%b fe=%b want v=0 pe=1 fe=0",
                  rd_valid, parity_err, frame_err);
      end
      pulse_clr();
      total++;
      if (parity_err !== 1'b0) begin
         bad++;
         $display("FAIL parity_clr got=%b want=0", parity_err);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] e;
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b0, 1'b1);
         total++;
         if (fifo_full !== (sb.size() == 4) || overflow !== exp_ovf) begin
            bad++;
            $display("FAIL fill_%0d got full=%b ovf=%b want full=%b ovf=%b",
                     i, fifo_full, overflow, sb.size() == 4, exp_ovf);
         end
      end
      while (sb.size() != 0) begin
         e = sb.pop_front();
         total++;
         if (rd_valid !== 1'b1 || rd_data !== {8'h00, e}) begin
            bad++;
            $display("FAIL drain got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, {8'h00, e});
         end
         rd_en = 1'b1;
         cyc(1);
         rd_en = 1'b0;
      end
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 16'h0000 || fifo_full !== 1'b0) begin
         bad++;
         $display("FAIL drained got v=%b d=%h full=%b want 0", rd_valid, rd_data, fifo_full);
      end
      pulse_clr();
      exp_ovf = 1'b0;
      total++;
      if (overflow !== exp_ovf) begin
         bad++;
         $display("FAIL ovf_clr got=%b want=0", overflow);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] e;
      send_bits(fbits(8'h55, 1'b0, 1'b1), 0, 5);
      cyc(TMO - 200);
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL tmo_early got=%b want=0", frame_err);
      end
      cyc(400);
      total++;
      if (frame_err !== 1'b1 || rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL tmo got fe=%b v=%b want fe=1 v=0", frame_err, rd_valid);
      end
      pulse_clr();
      send_frame(8'hF0, 1'b0, 1'b1);
      e = sb.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== {8'h00, e} || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL after_tmo got v=%b d=%h fe=%b want v=1 d=%h fe=0",
                  rd_valid, rd_data, frame_err, {8'h00, e});
      end
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
   endtask

   task automatic glitch();
      ps2c = 1'b0;
      cyc(3);
      ps2c = 1'b1;
      cyc(20);
   endtask

   task automatic test_glitch();
      logic [7:0] e;
      logic [10:0] f;
      glitch();
      f = fbits(8'h5A, 1'b0, 1'b1);
      send_bits(f, 0, 4);
      glitch();
      send_bits(f, 4, 11);
      model_push(8'h5A);
      cyc(HALF);
      e = sb.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== {8'h00, e} ||
          frame_err !== 1'b0 || parity_err !== 1'b0) begin
         bad++;
         $display("FAIL glitch got v=%b d=%h fe=%b pe=%b want v=1 d=%h fe=0 pe=0",
                  rd_valid, rd_data, frame_err, parity_err, {8'h00, e});
      end
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b0);
      total++;
      if (frame_err !== 1'b1 || parity_err !== 1'b0 || rd_valid !== (sb.size() != 0)) begin
         bad++;
         $display("FAIL stop0 got fe=%b pe=%b v=%b want fe=1 pe=0 v=0",
                  frame_err, parity_err, rd_valid);
      end
      pulse_clr();
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== {8'h00, sb[0]}) begin
         bad++;
         $display("FAIL pre_rst got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, {8'h00, sb[0]});
      end
      send_bits(fbits(8'h77, 1'b0, 1'b1), 0, 6);
      rst_n = 1'b0;
      #1;
      sb.delete();
      exp_ovf = 1'b0;
      total++;
      if ({rd_data, rd_valid, fifo_full, overflow, parity_err, frame_err} !== 21'h0) begin
         bad++;
         $display("FAIL rst_mid got=%h want=0",
                  {rd_data, rd_valid, fifo_full, overflow, parity_err, frame_err});
      end
      cyc(3);
      ps2c = 1'b1;
      ps2d = 1'b1;
      rst_n = 1'b1;
      cyc(20);
      send_frame(8'h29, 1'b0, 1'b1);
      e = sb.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== {8'h00, e} || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL post_rst got v=%b d=%h fe=%b want v=1 d=%h fe=0",
                  rd_valid, rd_data, frame_err, {8'h00, e});
      end
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
         bad++;
         $display("FAIL post_rst_only got v=%b d=%h want v=0 d=0000", rd_valid, rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_valid_frame();
      test_parity();
      test_overflow();
      test_timeout();
      test_glitch();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
